// File: rtl/fetch_controller.sv
// fetch_controller: Fetch-stage sequencer owning the PC, one outstanding imem request,
// stall hold buffer, Execute redirects and IF/ID enable/flush.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        IMemValid,
  input  logic [31:0] IMemRData,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrF,
  output logic        EnableD,
  output logic        FlushD,
  output logic [31:0] FetchCount
);
  localparam int BW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  typedef enum logic [2:0] {S_BOOT, S_ISSUE, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t r_state, w_next;
  logic [BW-1:0] r_boot;
  logic [31:0] r_pc, r_hold, r_count, w_pc_next, w_instr;
  logic w_req, w_en, w_flush, w_redir, w_load_hold;
  assign w_redir = PCSrcE && r_state != S_BOOT;
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_en        = 1'b0;
    w_flush     = w_redir;
    w_instr     = 32'h0;
    w_load_hold = 1'b0;
    case (r_state)
      S_BOOT:  begin
        w_flush = 1'b1;
        if (r_boot == BW'(BOOT_CYCLES - 1)) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_req = !w_redir;
        if (!w_redir) w_next = S_WAIT;
      end
      S_WAIT:  begin
        w_instr = IMemRData;
        if (w_redir) w_next = IMemValid ? S_ISSUE : S_DRAIN;
        else if (IMemValid) begin
          w_en        = !StallF;
          w_load_hold = StallF;
          w_next      = StallF ? S_HOLD : S_ISSUE;
        end
      end
      S_HOLD:  begin
        w_instr = r_hold;
        w_en    = !w_redir && !StallF;
        if (w_redir || !StallF) w_next = S_ISSUE;
      end
      S_DRAIN: if (IMemValid) w_next = S_ISSUE;
      default: w_next = S_BOOT;
    endcase
    w_pc_next = w_redir ? (PCTargetE & ~32'h3) : w_en ? r_pc + 32'd4 : r_pc;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_boot  <= '0;
      r_hold  <= 32'h0;
      r_count <= 32'h0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_boot  <= r_state == S_BOOT ? r_boot + 1'b1 : r_boot;
      r_hold  <= w_load_hold ? IMemRData : r_hold;
      r_count <= r_count + {31'h0, w_en};
    end
  end
  // Reset forces the bubble outputs combinationally, before the state register settles.
  assign IMemReq    = RST_N && w_req;
  assign EnableD    = RST_N && w_en;
  assign FlushD     = !RST_N || w_flush;
  assign InstrF     = RST_N ? w_instr : 32'h0;
  assign IMemAddr   = r_pc;
  assign PCF        = r_pc;
  assign PCPlus4F   = r_pc + 32'd4;
  assign FetchCount = r_count;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized bench with a transaction-level fetch model and a
// variable-latency instruction memory.
module tb_fetch_controller;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int BOOT = 2;
  logic CLK = 1'b0, RST_N = 1'b0, PCSrcE = 1'b0, StallF = 1'b0, IMemValid = 1'b0;
  logic [31:0] PCTargetE = 32'h0, IMemRData = 32'h0;
  logic IMemReq, EnableD, FlushD;
  logic [31:0] IMemAddr, PCF, PCPlus4F, InstrF, FetchCount;
  fetch_controller #(.RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT)) dut (
    .CLK(CLK), .RST_N(RST_N), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallF(StallF),
    .IMemValid(IMemValid), .IMemRData(IMemRData), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF), .EnableD(EnableD), .FlushD(FlushD),
    .FetchCount(FetchCount));
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;
  int lat_max = 1, stall_pct = 0, redir_pct = 0, rst_pm = 0, cyc = 0;
  bit force_rst = 1'b1, want_first = 1'b0;
  int m_boot = BOOT;
  logic [31:0] m_pc = RESET_PC, m_cnt = 32'h0, m_buf = 32'h0;
  bit m_out = 1'b0, m_stale = 1'b0, m_buf_v = 1'b0;
  bit mem_busy = 1'b0;
  int mem_left = 0;
  logic [31:0] mem_word = 32'h0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] pick_target();
    int k = $urandom_range(0, 3);
    return k == 0 ? 32'h0000_0103 : k == 1 ? 32'hFFFF_FFFF : $urandom();
  endfunction
  task automatic step();
    logic e_req, e_en, e_flush;
    logic [31:0] e_instr, tgt;
    @(negedge CLK);
    RST_N     = !(force_rst || $urandom_range(0, 999) < rst_pm);
    StallF    = $urandom_range(0, 99) < stall_pct;
    PCSrcE    = $urandom_range(0, 99) < redir_pct;
    PCTargetE = pick_target();
    IMemValid = mem_busy && mem_left == 0;
    IMemRData = IMemValid ? mem_word : $urandom();
    tgt       = PCTargetE & 32'hFFFF_FFFC;
    #1;
    e_req = 1'b0; e_en = 1'b0; e_flush = 1'b0; e_instr = 32'h0;
    if (!RST_N || m_boot > 0) e_flush = 1'b1;
    else if (m_buf_v) begin
      e_instr = m_buf;
      e_flush = PCSrcE;
      e_en    = !PCSrcE && !StallF;
    end else if (!m_out) begin
      e_req   = !PCSrcE;
      e_flush = PCSrcE;
    end else if (m_stale) e_flush = PCSrcE;
    else begin
      e_instr = IMemRData;
      e_flush = PCSrcE;
      e_en    = !PCSrcE && IMemValid && !StallF;
    end
    check("IMemReq", 32'(IMemReq), 32'(e_req));
    check("EnableD", 32'(EnableD), 32'(e_en));
    check("FlushD", 32'(FlushD), 32'(e_flush));
    if (e_en || !RST_N || m_boot > 0) check("InstrF", InstrF, e_instr);
    if (RST_N) begin
      check("PCF", PCF, m_pc);
      check("PCPlus4F", PCPlus4F, m_pc + 32'd4);
      check("IMemAddr", IMemAddr, m_pc);
      check("FetchCount", FetchCount, m_cnt);
      if (want_first && IMemReq) begin
        check("first_req_cycle", 32'(cyc), 32'd3);
        want_first = 1'b0;
      end
    end
    @(posedge CLK);
    if (!RST_N) begin
      m_boot = BOOT; m_pc = RESET_PC; m_cnt = 32'h0;
      m_out = 1'b0; m_stale = 1'b0; m_buf_v = 1'b0; mem_busy = 1'b0;
      cyc = 1; want_first = redir_pct == 0;
    end else begin
      cyc++;
      if (m_boot > 0) m_boot--;
      else if (m_buf_v) begin
        if (PCSrcE) begin m_pc = tgt; m_buf_v = 1'b0; end
        else if (!StallF) begin m_pc += 32'd4; m_cnt++; m_buf_v = 1'b0; end
      end else if (!m_out) begin
        if (PCSrcE) m_pc = tgt; else m_out = 1'b1;
      end else if (m_stale) begin
        if (PCSrcE) m_pc = tgt;
        if (IMemValid) begin m_out = 1'b0; m_stale = 1'b0; end
      end else if (PCSrcE) begin
        m_pc = tgt;
        if (IMemValid) m_out = 1'b0; else m_stale = 1'b1;
      end else if (IMemValid) begin
        m_out = 1'b0;
        if (StallF) begin m_buf_v = 1'b1; m_buf = IMemRData; end
        else begin m_pc += 32'd4; m_cnt++; end
      end
      if (IMemValid) mem_busy = 1'b0;
      else if (mem_busy) mem_left--;
      if (e_req) begin
        mem_busy = 1'b1;
        mem_left = $urandom_range(1, lat_max) - 1;
        mem_word = $urandom();
      end
    end
  endtask
  initial begin
    repeat (2) step();
    force_rst = 1'b0;
    repeat (20) step();
    stall_pct = 60;
    repeat (200) step();
    lat_max = 3; stall_pct = 20; redir_pct = 15;
    repeat (400) step();
    lat_max = 2; stall_pct = 30; redir_pct = 40;
    repeat (300) step();
    rst_pm = 20; redir_pct = 10;
    repeat (500) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
